// File: rtl/crc_pkg.sv
// Shared CRC checker definitions: task-table sizing, scheduler state encoding
// and the per-task redundancy mode used by the compare scheduler.
package crc_pkg;

  localparam int CRC_KEY_SIZE  = 16;
  localparam int CRC_KEY_WIDTH = 4;
  localparam int CRC_DEPTH     = 10;
  localparam int CRC_NUM_CORES = 3;

  typedef enum logic [1:0] {
    SCHED_IDLE       = 2'd0,
    SCHED_COMPARE    = 2'd1,
    SCHED_INC_TAIL   = 2'd2,
    SCHED_RESET_TASK = 2'd3
  } sched_state_e;

  typedef enum logic {
    MODE_TMR = 1'b0,
    MODE_DMR = 1'b1
  } task_mode_e;

  // Core 2 only takes part in the vote when the task runs triple-redundant.
  function automatic logic core_required(input task_mode_e mode, input logic [1:0] core);
    return (core < 2'd2) || (core == 2'd2 && mode == MODE_TMR);
  endfunction

endpackage

// File: rtl/comp_scheduler_rr_task_select.sv
// Round-robin selector: first ready task searching upward from last + 1,
// wrapping around so the last served task is considered last.
module rr_task_select #(
  parameter int NUM_TASKS = 16,
  parameter int KEY_W     = 4
) (
  input  logic [NUM_TASKS-1:0] ready,
  input  logic [KEY_W-1:0]     last,
  output logic [KEY_W-1:0]     grant,
  output logic                 grant_vld
);

  always_comb begin
    logic [KEY_W-1:0] sel;
    grant     = '0;
    grant_vld = 1'b0;
    sel       = '0;
    for (int i = 1; i <= NUM_TASKS; i++) begin
      sel = KEY_W'((int'(last) + i) % NUM_TASKS);
      if (!grant_vld && ready[sel]) begin
        grant_vld = 1'b1;
        grant     = sel;
      end
    end
  end

endmodule

// File: rtl/comp_scheduler.sv
// Fingerprint compare scheduler: tracks pending fingerprints per task and core,
// and sequences compare / tail-increment / task-reset handshakes for ready tasks.
module comp_scheduler
  import crc_pkg::*;
#(
  parameter int NUM_TASKS = CRC_KEY_SIZE,
  parameter int KEY_W     = CRC_KEY_WIDTH,
  parameter int DEPTH     = CRC_DEPTH
) (
  input  logic                 clk,
  input  logic                 comp_reset_task_ack,
  input  logic                 push_valid,
  input  logic [KEY_W-1:0]     push_task,
  input  logic [1:0]           push_core,
  input  logic                 mode_write,
  input  logic [KEY_W-1:0]     mode_task,
  input  logic                 mode_dmr,
  output logic                 cmp_req,
  output logic [KEY_W-1:0]     cmp_task,
  input  logic                 cmp_ack,
  input  logic                 cmp_mismatch,
  output logic                 inc_tail_req,
  output logic [KEY_W-1:0]     inc_tail_task,
  input  logic                 inc_tail_ack,
  output logic                 rst_task_req,
  output logic [KEY_W-1:0]     rst_task_id,
  input  logic                 rst_task_done,
  output logic                 mismatch_pulse,
  output logic [KEY_W-1:0]     mismatch_task,
  output logic [NUM_TASKS-1:0] overflow
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  sched_state_e         state;
  logic [KEY_W-1:0]     cur_task;
  logic [KEY_W-1:0]     last_task;
  logic [CNT_W-1:0]     cnt     [CRC_NUM_CORES][NUM_TASKS];
  task_mode_e           mode_q  [NUM_TASKS];
  logic [NUM_TASKS-1:0] inc_vec [CRC_NUM_CORES];
  logic [NUM_TASKS-1:0] dec_vec;
  logic [NUM_TASKS-1:0] clr_vec;
  logic [NUM_TASKS-1:0] ovf_set;
  logic [NUM_TASKS-1:0] ready;
  logic [KEY_W-1:0]     grant;
  logic                 grant_vld;

  always_comb begin
    ready = '1;
    for (int t = 0; t < NUM_TASKS; t++) begin
      for (int c = 0; c < CRC_NUM_CORES; c++) begin
        if (core_required(mode_q[t], 2'(c)) && cnt[c][t] == '0) begin
          ready[t] = 1'b0;
        end
      end
    end
  end

  rr_task_select #(
    .NUM_TASKS (NUM_TASKS),
    .KEY_W     (KEY_W)
  ) u_rr_task_select (
    .ready     (ready),
    .last      (last_task),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // Per-cycle counter events; core 3 pushes belong to no compare group.
  always_comb begin
    dec_vec = '0;
    clr_vec = '0;
    ovf_set = '0;
    for (int c = 0; c < CRC_NUM_CORES; c++) begin
      inc_vec[c] = '0;
      if (push_valid && push_core == 2'(c)) begin
        inc_vec[c][push_task] = 1'b1;
      end
    end
    if (state == SCHED_INC_TAIL && inc_tail_ack) begin
      dec_vec[cur_task] = 1'b1;
    end
    if (state == SCHED_RESET_TASK && rst_task_done) begin
      clr_vec[cur_task] = 1'b1;
    end
    for (int t = 0; t < NUM_TASKS; t++) begin
      for (int c = 0; c < CRC_NUM_CORES; c++) begin
        if (inc_vec[c][t] && !dec_vec[t] && !clr_vec[t] && cnt[c][t] == CNT_MAX) begin
          ovf_set[t] = 1'b1;
        end
      end
    end
  end

  // A push that meets a decrement cancels out; a clear always wins.
  always_ff @(posedge clk or posedge comp_reset_task_ack) begin
    if (comp_reset_task_ack) begin
      for (int c = 0; c < CRC_NUM_CORES; c++) begin
        for (int t = 0; t < NUM_TASKS; t++) begin
          cnt[c][t] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < CRC_NUM_CORES; c++) begin
        for (int t = 0; t < NUM_TASKS; t++) begin
          if (clr_vec[t]) begin
            cnt[c][t] <= '0;
          end else if (inc_vec[c][t] && !dec_vec[t]) begin
            if (cnt[c][t] != CNT_MAX) begin
              cnt[c][t] <= cnt[c][t] + CNT_W'(1);
            end
          end else if (dec_vec[t] && !inc_vec[c][t] && cnt[c][t] != '0) begin
            cnt[c][t] <= cnt[c][t] - CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge comp_reset_task_ack) begin
    if (comp_reset_task_ack) begin
      overflow <= '0;
      for (int t = 0; t < NUM_TASKS; t++) begin
        mode_q[t] <= MODE_TMR;
      end
    end else begin
      overflow <= overflow | ovf_set;
      if (mode_write) begin
        mode_q[mode_task] <= task_mode_e'(mode_dmr);
      end
    end
  end

  always_ff @(posedge clk or posedge comp_reset_task_ack) begin
    if (comp_reset_task_ack) begin
      state          <= SCHED_IDLE;
      cur_task       <= '0;
      last_task      <= KEY_W'(NUM_TASKS - 1);
      cmp_req        <= 1'b0;
      cmp_task       <= '0;
      inc_tail_req   <= 1'b0;
      inc_tail_task  <= '0;
      rst_task_req   <= 1'b0;
      rst_task_id    <= '0;
      mismatch_pulse <= 1'b0;
      mismatch_task  <= '0;
    end else begin
      mismatch_pulse <= 1'b0;
      case (state)
        SCHED_IDLE: begin
          if (grant_vld) begin
            state     <= SCHED_COMPARE;
            cur_task  <= grant;
            last_task <= grant;
            cmp_req   <= 1'b1;
            cmp_task  <= grant;
          end
        end
        SCHED_COMPARE: begin
          if (cmp_ack) begin
            cmp_req <= 1'b0;
            if (!cmp_mismatch) begin
              state         <= SCHED_INC_TAIL;
              inc_tail_req  <= 1'b1;
              inc_tail_task <= cur_task;
            end else begin
              state          <= SCHED_RESET_TASK;
              mismatch_pulse <= 1'b1;
              mismatch_task  <= cur_task;
              rst_task_req   <= 1'b1;
              rst_task_id    <= cur_task;
            end
          end
        end
        SCHED_INC_TAIL: begin
          if (inc_tail_ack) begin
            inc_tail_req <= 1'b0;
            state        <= SCHED_IDLE;
          end
        end
        SCHED_RESET_TASK: begin
          if (rst_task_done) begin
            rst_task_req <= 1'b0;
            state        <= SCHED_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_scheduler.sv
// Bench for comp_scheduler: transaction-level reference model plus directed scenarios.
module tb_comp_scheduler;
  import crc_pkg::*;

  localparam int N  = 16;
  localparam int KW = 4;
  localparam int D  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid;
  logic [KW-1:0] push_task;
  logic [1:0]    push_core;
  logic          mode_write;
  logic [KW-1:0] mode_task;
  logic          mode_dmr;
  logic          cmp_req;
  logic [KW-1:0] cmp_task;
  logic          cmp_ack;
  logic          cmp_mismatch;
  logic          inc_tail_req;
  logic [KW-1:0] inc_tail_task;
  logic          inc_tail_ack;
  logic          rst_task_req;
  logic [KW-1:0] rst_task_id;
  logic          rst_task_done;
  logic          mismatch_pulse;
  logic [KW-1:0] mismatch_task;
  logic [N-1:0]  overflow;

  always #5 clk = ~clk;

  comp_scheduler #(.NUM_TASKS(N), .KEY_W(KW), .DEPTH(D)) dut (
    .clk                 (clk),
    .comp_reset_task_ack (rst),
    .push_valid          (push_valid),
    .push_task           (push_task),
    .push_core           (push_core),
    .mode_write          (mode_write),
    .mode_task           (mode_task),
    .mode_dmr            (mode_dmr),
    .cmp_req             (cmp_req),
    .cmp_task            (cmp_task),
    .cmp_ack             (cmp_ack),
    .cmp_mismatch        (cmp_mismatch),
    .inc_tail_req        (inc_tail_req),
    .inc_tail_task       (inc_tail_task),
    .inc_tail_ack        (inc_tail_ack),
    .rst_task_req        (rst_task_req),
    .rst_task_id         (rst_task_id),
    .rst_task_done       (rst_task_done),
    .mismatch_pulse      (mismatch_pulse),
    .mismatch_task       (mismatch_task),
    .overflow            (overflow)
  );

  // Reference model: pending fingerprint counts, modes and the service step in progress.
  int       m_cnt [3][N];
  bit [N-1:0] m_dmr;
  bit [N-1:0] m_ovf;
  int       m_last, m_cur, m_phase;   // phase: 0 waiting, 1 comparing, 2 tail, 3 resetting
  bit       e_cmp_req, e_inc_req, e_rst_req, e_mp;
  int       e_cmp_task, e_inc_task, e_rst_id, e_mtask;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    for (int c = 0; c < 3; c++) for (int t = 0; t < N; t++) m_cnt[c][t] = 0;
    m_dmr = '0; m_ovf = '0; m_last = N - 1; m_cur = 0; m_phase = 0;
    e_cmp_req = 0; e_inc_req = 0; e_rst_req = 0; e_mp = 0;
    e_cmp_task = 0; e_inc_task = 0; e_rst_id = 0; e_mtask = 0;
  endtask

  function automatic bit m_ready(int t);
    return m_cnt[0][t] > 0 && m_cnt[1][t] > 0 && (m_dmr[t] || m_cnt[2][t] > 0);
  endfunction

  // Predict the state after the coming rising edge from the inputs now applied.
  task automatic model_step();
    int dec_t = -1;
    int clr_t = -1;
    e_mp = 0;
    case (m_phase)
      0: begin
        for (int k = 1; k <= N; k++) begin
          if (m_phase == 0 && m_ready((m_last + k) % N)) begin
            m_cur = (m_last + k) % N; m_last = m_cur; m_phase = 1;
            e_cmp_req = 1; e_cmp_task = m_cur;
          end
        end
      end
      1: if (cmp_ack) begin
        e_cmp_req = 0;
        if (!cmp_mismatch) begin
          m_phase = 2; e_inc_req = 1; e_inc_task = m_cur;
        end else begin
          m_phase = 3; e_mp = 1; e_mtask = m_cur; e_rst_req = 1; e_rst_id = m_cur;
        end
      end
      2: if (inc_tail_ack) begin dec_t = m_cur; e_inc_req = 0; m_phase = 0; end
      default: if (rst_task_done) begin clr_t = m_cur; e_rst_req = 0; m_phase = 0; end
    endcase
    for (int t = 0; t < N; t++) begin
      for (int c = 0; c < 3; c++) begin
        bit inc;
        inc = push_valid && int'(push_core) == c && int'(push_task) == t;
        if (t == clr_t) m_cnt[c][t] = 0;
        else if (inc && t == dec_t) m_cnt[c][t] = m_cnt[c][t];
        else if (inc) begin
          if (m_cnt[c][t] == D) m_ovf[t] = 1;
          else m_cnt[c][t] = m_cnt[c][t] + 1;
        end else if (t == dec_t && m_cnt[c][t] > 0) m_cnt[c][t] = m_cnt[c][t] - 1;
      end
    end
    if (mode_write) m_dmr[mode_task] = mode_dmr;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("cmp_req", 32'(cmp_req), 32'(e_cmp_req));
    chk("cmp_task", 32'(cmp_task), 32'(e_cmp_task));
    chk("inc_tail_req", 32'(inc_tail_req), 32'(e_inc_req));
    chk("inc_tail_task", 32'(inc_tail_task), 32'(e_inc_task));
    chk("rst_task_req", 32'(rst_task_req), 32'(e_rst_req));
    chk("rst_task_id", 32'(rst_task_id), 32'(e_rst_id));
    chk("mismatch_pulse", 32'(mismatch_pulse), 32'(e_mp));
    chk("mismatch_task", 32'(mismatch_task), 32'(e_mtask));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic clear_in();
    push_valid = 0; push_task = '0; push_core = '0;
    mode_write = 0; mode_task = '0; mode_dmr = 0;
    cmp_ack = 0; cmp_mismatch = 0; inc_tail_ack = 0; rst_task_done = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic push(int t, int c);
    clear_in(); push_valid = 1; push_task = KW'(t); push_core = 2'(c); step();
  endtask

  task automatic idle(int n);
    repeat (n) begin clear_in(); step(); end
  endtask

  task automatic ack_cmp(bit mis);
    clear_in(); cmp_ack = 1; cmp_mismatch = mis; step();
  endtask

  task automatic ack_inc();
    clear_in(); inc_tail_ack = 1; step();
  endtask

  task automatic done_rst();
    clear_in(); rst_task_done = 1; step();
  endtask

  task automatic do_reset();
    clear_in(); rst = 1; model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 0;
    check_outputs();
  endtask

  initial begin
    clear_in();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_cmp_req", 32'(cmp_req), 0);
    chk("reset_overflow", 32'(overflow), 0);
    rst = 0;

    // TMR task 2: full service with a clean compare.
    do_reset();
    push(2, 0); push(2, 1); push(2, 2);
    idle(1);
    chk("t2_cmp_req", 32'(cmp_req), 1);
    chk("t2_cmp_task", 32'(cmp_task), 2);
    ack_cmp(0);
    chk("t2_inc_req", 32'(inc_tail_req), 1);
    chk("t2_inc_task", 32'(inc_tail_task), 2);
    chk("t2_cmp_drop", 32'(cmp_req), 0);
    ack_inc();
    chk("t2_inc_drop", 32'(inc_tail_req), 0);
    idle(4);
    chk("t2_drained", 32'(cmp_req), 0);

    // DMR task 5 needs only cores 0/1; TMR task 6 does not.
    do_reset();
    clear_in(); mode_write = 1; mode_task = 4'd5; mode_dmr = 1; step();
    push(5, 0); push(5, 1);
    idle(1);
    chk("t5_dmr_cmp_req", 32'(cmp_req), 1);
    chk("t5_dmr_cmp_task", 32'(cmp_task), 5);
    ack_cmp(0); ack_inc();
    push(6, 0); push(6, 1);
    idle(4);
    chk("t6_tmr_no_cmp", 32'(cmp_req), 0);

    // Round robin: after serving 3, with 3 and 7 ready, 7 goes first.
    do_reset();
    push(3, 0); push(3, 1); push(3, 2);
    idle(1);
    chk("rr_first_3", 32'(cmp_task), 3);
    for (int c = 0; c < 3; c++) push(3, c);
    for (int c = 0; c < 3; c++) push(7, c);
    ack_cmp(0); ack_inc();
    idle(1);
    chk("rr_then_7", 32'(cmp_task), 7);
    ack_cmp(0); ack_inc();
    idle(1);
    chk("rr_then_3", 32'(cmp_task), 3);
    ack_cmp(0); ack_inc();

    // Mismatch on task 4 resets the task instead of advancing its tail.
    do_reset();
    push(4, 0); push(4, 1); push(4, 2);
    idle(1);
    chk("t4_cmp_task", 32'(cmp_task), 4);
    ack_cmp(1);
    chk("t4_mm_pulse", 32'(mismatch_pulse), 1);
    chk("t4_mm_task", 32'(mismatch_task), 4);
    chk("t4_rst_req", 32'(rst_task_req), 1);
    chk("t4_rst_id", 32'(rst_task_id), 4);
    chk("t4_no_inc", 32'(inc_tail_req), 0);
    idle(1);
    chk("t4_pulse_one_cycle", 32'(mismatch_pulse), 0);
    chk("t4_rst_held", 32'(rst_task_req), 1);
    done_rst();
    chk("t4_rst_drop", 32'(rst_task_req), 0);
    idle(4);
    chk("t4_cleared", 32'(cmp_req), 0);
    chk("t4_no_inc_after", 32'(inc_tail_req), 0);

    // Overflow on task 1 core 0, then reset while comparing.
    do_reset();
    repeat (10) push(1, 0);
    chk("t1_full_no_ovf", 32'(overflow), 0);
    push(1, 0);
    chk("t1_overflow", 32'(overflow), 32'h0002);
    push(1, 1); push(1, 2);
    idle(1);
    chk("t1_cmp_req", 32'(cmp_req), 1);
    chk("t1_cmp_task", 32'(cmp_task), 1);
    clear_in(); rst = 1;
    #1;
    chk("async_rst_cmp_req", 32'(cmp_req), 0);
    chk("async_rst_cmp_task", 32'(cmp_task), 0);
    chk("async_rst_overflow", 32'(overflow), 0);
    chk("async_rst_others", 32'({inc_tail_req, rst_task_req, mismatch_pulse}), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    check_outputs();

    // Randomized traffic with responders driven from the model's view of the requests.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2000) do_reset();
      clear_in();
      if ($urandom_range(0, 99) < 60) begin
        push_valid = 1;
        push_task  = ($urandom_range(0, 1) == 0) ? KW'($urandom_range(0, 3)) : KW'($urandom_range(0, N - 1));
        push_core  = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 99) < 3) begin
        mode_write = 1; mode_task = KW'($urandom_range(0, N - 1)); mode_dmr = 1'($urandom_range(0, 1));
      end
      cmp_mismatch  = ($urandom_range(0, 99) < 20);
      cmp_ack       = e_cmp_req && ($urandom_range(0, 99) < 40);
      inc_tail_ack  = e_inc_req && ($urandom_range(0, 99) < 50);
      rst_task_done = e_rst_req && ($urandom_range(0, 99) < 40);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/comp_scheduler.md
COMP_SCHEDULER -- requirements
Module: comp_scheduler

Interface
REQ-001 SHALL have parameter NUM_TASKS, default 16, meaning number of task slots (equals CRC_KEY_SIZE).
REQ-002 SHALL have parameter KEY_W, default 4, meaning task-id width (equals CRC_KEY_WIDTH).
REQ-003 SHALL have parameter DEPTH, default 10, meaning fingerprint slots per task per logical core.
REQ-004 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port comp_reset_task_ack  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port push_valid  in  1  single-cycle pulse: a fingerprint was written at a head pointer.
REQ-007 SHALL have ports push_task  in  KEY_W  and push_core  in  2, meaning the task and logical core of the push.
REQ-008 SHALL have ports mode_write  in  1, mode_task  in  KEY_W, mode_dmr  in  1, meaning the CSR write of the per-task mode (1 = DMR, cores 0/1; 0 = TMR, cores 0/1/2).
REQ-009 SHALL have ports cmp_req  out  1, cmp_task  out  KEY_W, cmp_ack  in  1, cmp_mismatch  in  1, meaning the comparator handshake; cmp_mismatch is valid with cmp_ack.
REQ-010 SHALL have ports inc_tail_req  out  1, inc_tail_task  out  KEY_W, inc_tail_ack  in  1, meaning the tail-increment handshake to comp_registers.
REQ-011 SHALL have ports rst_task_req  out  1, rst_task_id  out  KEY_W, rst_task_done  in  1, meaning the task-reset handshake to comp_registers.
REQ-012 SHALL have ports mismatch_pulse  out  1, mismatch_task  out  KEY_W, overflow  out  NUM_TASKS, meaning error reporting.

Function
REQ-013 SHALL keep one pending counter (0..DEPTH) per task per core (3 x NUM_TASKS counters).
REQ-014 SHALL increment the selected counter on push_valid; at DEPTH SHALL hold the counter, drop the push, and set overflow[push_task] (sticky).
REQ-015 SHALL mark a task ready when all counters of its required cores (per mode) are nonzero; push_core==3 SHALL be ignored.
REQ-016 SHALL implement FSM states IDLE, COMPARE, INC_TAIL, RESET_TASK.
REQ-017 IDLE: SHALL select the ready task round-robin, starting from (last served + 1) mod NUM_TASKS, and move to COMPARE in the next cycle; with no task ready it SHALL stay in IDLE.
REQ-018 COMPARE: SHALL hold cmp_req=1 with a stable cmp_task until the cycle cmp_ack=1; it SHALL then go to INC_TAIL if cmp_mismatch=0, else to RESET_TASK.
REQ-019 INC_TAIL: SHALL hold inc_tail_req=1 until inc_tail_ack; on ack it SHALL decrement all three counters of the task (saturating at 0) and return to IDLE.
REQ-020 RESET_TASK: SHALL pulse mismatch_pulse for 1 cycle on entry with mismatch_task valid, hold rst_task_req=1 until rst_task_done, and then clear the task's three counters and return to IDLE.
REQ-021 A push and a decrement to the same counter in the same cycle SHALL leave it unchanged; a push in the same cycle as a clear SHALL be lost.
REQ-022 A request SHALL be deasserted in the cycle after its ack; the minimum period between successive cmp_req assertions SHALL be 3 cycles.
REQ-023 A mode_write SHALL take effect on the next readiness evaluation; it SHALL not abort an in-flight sequence.

Reset
REQ-024 On comp_reset_task_ack SHALL: FSM=IDLE, all counters=0, all modes=TMR, overflow=0, round-robin pointer=NUM_TASKS-1, every req/pulse output=0, and task outputs=0.

Structure
REQ-025 State encoding enum, DEPTH, and the mode encoding SHALL live in the shared crc package next to the CRC_* defines.
REQ-026 The round-robin ready selector SHALL be one sub-module, rr_task_select (ready vector + last index in, grant index + valid out, combinational).

Verification
REQ-027 Task 2 TMR: push cores 0,1,2 -> cmp_req with cmp_task=2; ack, no mismatch -> inc_tail_req task 2; after ack, counters all 0.
REQ-028 Task 5 DMR: push cores 0,1 -> compare is issued without core 2; the same pushes on a TMR task -> no cmp_req.
REQ-029 Tasks 3 and 7 both ready, last served=3 -> 7 is served first, then 3.
REQ-030 Mismatch on task 4 -> mismatch_pulse 1 cycle with mismatch_task=4 and rst_task_req; after done, counters 0 and no inc_tail_req.
REQ-031 11 pushes to task 1 core 0 -> counter=10 and overflow[1]=1; assert reset mid-COMPARE -> all outputs 0 next cycle.
